// File: rtl/image_multi_loader_if.sv
// Bundle of load-control, BRAM and pixel-output signals for image_multi_loader.
// The slave side is the loader; the master side is whoever drives loads and
// provides the BRAM read data.
interface image_multi_loader_if #(
  parameter int P_NUM_INPUT_PIXELS     = 784,
  parameter int P_PIXEL_INTENSITY_BITS = 8,
  parameter int P_BRAM_DATA_WIDTH      = 64,
  parameter int P_NUM_IMAGES           = 16
) ();
  localparam int PPW = P_BRAM_DATA_WIDTH / P_PIXEL_INTENSITY_BITS;
  localparam int WPI = (P_NUM_INPUT_PIXELS + PPW - 1) / PPW;
  localparam int AW  = $clog2(P_NUM_IMAGES * WPI);
  localparam int IW  = (P_NUM_IMAGES > 1) ? $clog2(P_NUM_IMAGES) : 1;

  logic                                                  i_load_image_start;
  logic [IW-1:0]                                         i_image_index;
  logic                                                  i_pixel_order;
  logic                                                  i_abort;
  logic [P_BRAM_DATA_WIDTH-1:0]                          i_bram_dout_raw;
  logic [AW-1:0]                                         o_bram_addr;
  logic                                                  o_bram_ena;
  logic [P_NUM_INPUT_PIXELS*P_PIXEL_INTENSITY_BITS-1:0]  o_image_buffer_out;
  logic                                                  o_loading_busy;
  logic                                                  o_load_done;
  logic                                                  o_load_aborted;
  logic                                                  o_start_error;

  modport slave (
    input  i_load_image_start, i_image_index, i_pixel_order, i_abort, i_bram_dout_raw,
    output o_bram_addr, o_bram_ena, o_image_buffer_out, o_loading_busy,
           o_load_done, o_load_aborted, o_start_error
  );

  modport master (
    output i_load_image_start, i_image_index, i_pixel_order, i_abort, i_bram_dout_raw,
    input  o_bram_addr, o_bram_ena, o_image_buffer_out, o_loading_busy,
           o_load_done, o_load_aborted, o_start_error
  );
endinterface

// File: rtl/image_multi_loader.sv
// Loads one of several images packed back-to-back in a BRAM, unpacks the
// words into raster pixel order and publishes the whole image at once when
// every word has arrived. Aborted loads never disturb the published image.
module image_multi_loader #(
  parameter int P_NUM_INPUT_PIXELS     = 784,
  parameter int P_PIXEL_INTENSITY_BITS = 8,
  parameter int P_BRAM_DATA_WIDTH      = 64,
  parameter int P_NUM_IMAGES           = 16,
  parameter int P_BRAM_READ_LATENCY    = 2
) (
  input logic                 clk,
  input logic                 rst,
  image_multi_loader_if.slave bus
);
  localparam int N   = P_NUM_INPUT_PIXELS;
  localparam int B   = P_PIXEL_INTENSITY_BITS;
  localparam int W   = P_BRAM_DATA_WIDTH;
  localparam int L   = P_BRAM_READ_LATENCY;
  localparam int PPW = W / B;
  localparam int WPI = (N + PPW - 1) / PPW;
  localparam int AW  = $clog2(P_NUM_IMAGES * WPI);
  localparam int IW  = (P_NUM_IMAGES > 1) ? $clog2(P_NUM_IMAGES) : 1;
  localparam int CW  = $clog2(WPI + 1);
  localparam int SW  = (WPI > 1) ? $clog2(WPI) : 1;

  localparam logic [IW:0]   LP_NIMG     = P_NUM_IMAGES[IW:0];
  localparam logic [AW-1:0] LP_WPI_A    = WPI[AW-1:0];
  localparam logic [CW-1:0] LP_LAST_ISS = CW'(WPI - 1);
  localparam logic [CW-1:0] LP_ALL_CAP  = CW'(WPI);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_FLUSH, S_DONE} state_t;

  state_t          r_state;
  state_t          w_next;
  logic            w_accept;
  logic            w_reject;
  logic            w_abort;
  logic            w_ena;
  logic            w_busy;
  logic            w_idx_ok;
  logic            w_capture;
  logic [SW-1:0]   w_cap_idx;
  logic [N*B-1:0]  w_unpacked;

  logic [AW-1:0]   r_addr;
  logic [CW-1:0]   r_issue;
  logic [CW-1:0]   r_cap;
  logic [L-1:0]    r_vld;
  logic            r_order;
  logic            r_aborted;
  logic            r_start_err;
  logic [W-1:0]    r_shadow [WPI];
  logic [N*B-1:0]  r_image;

  assign w_idx_ok  = ({1'b0, bus.i_image_index} < LP_NIMG);
  // Abort wins over a capture landing on the same edge.
  assign w_capture = r_vld[L-1] && !w_abort;
  assign w_cap_idx = r_cap[SW-1:0];

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // Next-state and control decode; DONE behaves like IDLE for new starts.
  always_comb begin
    w_next   = r_state;
    w_accept = 1'b0;
    w_reject = 1'b0;
    w_abort  = 1'b0;
    w_ena    = 1'b0;
    w_busy   = 1'b0;
    case (r_state)
      S_IDLE, S_DONE: begin
        w_next = S_IDLE;
        if (bus.i_load_image_start && !bus.i_abort) begin
          if (w_idx_ok) begin
            w_accept = 1'b1;
            w_next   = S_LOAD;
          end else begin
            w_reject = 1'b1;
          end
        end
      end
      S_LOAD: begin
        w_ena  = 1'b1;
        w_busy = 1'b1;
        if (bus.i_abort) begin
          w_abort = 1'b1;
          w_next  = S_IDLE;
        end else if (r_issue == LP_LAST_ISS) begin
          w_next = S_FLUSH;
        end
      end
      S_FLUSH: begin
        w_busy = 1'b1;
        if (bus.i_abort) begin
          w_abort = 1'b1;
          w_next  = S_IDLE;
        end else if (r_cap == LP_ALL_CAP) begin
          w_next = S_DONE;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Issue address/counters, BRAM valid pipeline, capture counter and pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_addr      <= '0;
      r_issue     <= '0;
      r_cap       <= '0;
      r_vld       <= '0;
      r_order     <= 1'b0;
      r_aborted   <= 1'b0;
      r_start_err <= 1'b0;
    end else begin
      r_aborted   <= w_abort;
      r_start_err <= w_reject;
      if (w_accept) begin
        r_addr  <= AW'(bus.i_image_index) * LP_WPI_A;
        r_issue <= '0;
        r_order <= bus.i_pixel_order;
      end else if (w_ena && !w_abort) begin
        r_issue <= r_issue + 1'b1;
        // Hold the last address rather than stepping past the image.
        if (r_issue != LP_LAST_ISS) r_addr <= r_addr + 1'b1;
      end
      if (w_abort) begin
        r_vld <= '0;
      end else begin
        r_vld[0] <= w_ena;
        for (int i = 1; i < L; i++) r_vld[i] <= r_vld[i-1];
      end
      if (w_accept || w_abort) r_cap <= '0;
      else if (w_capture)      r_cap <= r_cap + 1'b1;
    end
  end

  // Shadow word store, indexed by word offset within the image.
  always_ff @(posedge clk) begin
    if (w_capture) r_shadow[w_cap_idx] <= bus.i_bram_dout_raw;
  end

  // Static unpack: padding slots beyond pixel N-1 are simply never selected.
  for (genvar g = 0; g < N; g++) begin : g_px
    assign w_unpacked[(N-1-g)*B +: B] = r_order ?
      r_shadow[g/PPW][(g%PPW)*B +: B] :
      r_shadow[g/PPW][W-1-(g%PPW)*B -: B];
  end

  // Publish the unpacked image on entry to DONE only.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                  r_image <= '0;
    else if (w_next == S_DONE) r_image <= w_unpacked;
  end

  assign bus.o_bram_addr        = r_addr;
  assign bus.o_bram_ena         = w_ena;
  assign bus.o_image_buffer_out = r_image;
  assign bus.o_loading_busy     = w_busy;
  assign bus.o_load_done        = (r_state == S_DONE);
  assign bus.o_load_aborted     = r_aborted;
  assign bus.o_start_error      = r_start_err;
endmodule

// File: tb/tb_image_multi_loader.sv
// Bench for image_multi_loader: a default-size instance and a small
// N=10 / L=3 / 3-image instance, each fed by a latency-accurate BRAM model.
module tb_image_multi_loader;
  localparam int N0 = 784, NI0 = 16, L0 = 2, WPI0 = 98, AW0 = 11;
  localparam int N1 = 10,  NI1 = 3,  L1 = 3, WPI1 = 2,  AW1 = 3;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  image_multi_loader_if #(.P_NUM_INPUT_PIXELS(N0), .P_PIXEL_INTENSITY_BITS(8),
    .P_BRAM_DATA_WIDTH(64), .P_NUM_IMAGES(NI0)) b0 ();
  image_multi_loader_if #(.P_NUM_INPUT_PIXELS(N1), .P_PIXEL_INTENSITY_BITS(8),
    .P_BRAM_DATA_WIDTH(64), .P_NUM_IMAGES(NI1)) b1 ();

  image_multi_loader #(.P_NUM_INPUT_PIXELS(N0), .P_PIXEL_INTENSITY_BITS(8),
    .P_BRAM_DATA_WIDTH(64), .P_NUM_IMAGES(NI0), .P_BRAM_READ_LATENCY(L0))
    u0 (.clk(clk), .rst(rst), .bus(b0));
  image_multi_loader #(.P_NUM_INPUT_PIXELS(N1), .P_PIXEL_INTENSITY_BITS(8),
    .P_BRAM_DATA_WIDTH(64), .P_NUM_IMAGES(NI1), .P_BRAM_READ_LATENCY(L1))
    u1 (.clk(clk), .rst(rst), .bus(b1));

  logic [63:0] mem0 [NI0*WPI0];
  logic [63:0] mem1 [NI1*WPI1];
  logic [63:0] dp0 [L0];
  logic [63:0] dp1 [L1];

  // BRAM models: data for an enabled address appears L cycles later; junk otherwise.
  always @(posedge clk) begin
    dp0[0] <= b0.o_bram_ena ? mem0[b0.o_bram_addr] : {$urandom, $urandom};
    dp0[1] <= dp0[0];
    dp1[0] <= b1.o_bram_ena ? mem1[b1.o_bram_addr] : {$urandom, $urandom};
    dp1[1] <= dp1[0];
    dp1[2] <= dp1[1];
  end
  assign b0.i_bram_dout_raw = dp0[L0-1];
  assign b1.i_bram_dout_raw = dp1[L1-1];

  int n_chk  = 0;
  int n_pass = 0;

  // Reference pixel: raster r lives in word r/8, slot r%8; order picks the end.
  function automatic logic [7:0] px0(int idx, bit ord, int r);
    logic [63:0] w;
    int sh;
    w  = mem0[11'(idx*WPI0 + r/8)];
    sh = ord ? 8*(r%8) : 56 - 8*(r%8);
    return 8'((w >> sh) & 64'hFF);
  endfunction

  function automatic logic [7:0] px1(int idx, bit ord, int r);
    logic [63:0] w;
    int sh;
    w  = mem1[3'(idx*WPI1 + r/8)];
    sh = ord ? 8*(r%8) : 56 - 8*(r%8);
    return 8'((w >> sh) & 64'hFF);
  endfunction

  function automatic logic [7:0] out0(int r);
    return b0.o_image_buffer_out[13'((N0-1-r)*8) +: 8];
  endfunction

  function automatic int img_bad0(int idx, bit ord);
    int bad = 0;
    for (int r = 0; r < N0; r++) if (out0(r) !== px0(idx, ord, r)) bad++;
    return bad;
  endfunction

  function automatic int img_bad1(int idx, bit ord);
    int bad = 0;
    for (int r = 0; r < N1; r++)
      if (b1.o_image_buffer_out[7'((N1-1-r)*8) +: 8] !== px1(idx, ord, r)) bad++;
    return bad;
  endfunction

  // Runs one load on the default instance starting at the current negedge and
  // observes it cycle by cycle (cycle 0 = first cycle after the accepting edge).
  task automatic drive_load0(input int idx, input bit ord, input int abort_at,
      input int rst_at, input int mid_at, output int done_cyc, output int ena_cnt,
      output int addr_bad, output int abort_cyc, output int ena_after_abort,
      output int busy_bad, output bit rst_zero);
    bit rst_seen = 0;
    done_cyc = -1; ena_cnt = 0; addr_bad = 0; abort_cyc = -1;
    ena_after_abort = 0; busy_bad = 0; rst_zero = 0;
    b0.i_load_image_start = 1'b1;
    b0.i_image_index      = 4'(idx);
    b0.i_pixel_order      = ord;
    @(negedge clk);
    b0.i_load_image_start = 1'b0;
    b0.i_image_index      = 4'($urandom);
    b0.i_pixel_order      = 1'($urandom);
    for (int c = 0; c < 200; c++) begin
      if (c > 0) @(negedge clk);
      if (b0.o_load_aborted && abort_cyc < 0) abort_cyc = c;
      if (b0.o_bram_ena) begin
        ena_cnt++;
        if (abort_cyc >= 0) ena_after_abort++;
        if (b0.o_bram_addr !== AW0'(idx*WPI0 + c)) addr_bad++;
      end
      if (b0.o_load_done) begin
        done_cyc = c;
        break;
      end
      if (abort_cyc < 0 && !rst_seen && !b0.o_loading_busy) busy_bad++;
      if (abort_cyc >= 0 && c >= abort_cyc + 3) break;
      b0.i_abort = (c == abort_at);
      b0.i_load_image_start = (c == mid_at);
      if (c == rst_at) begin
        rst = 1'b1;
        #1;
        rst_zero = (b0.o_bram_ena === 1'b0) && (b0.o_bram_addr === '0) &&
                   (b0.o_image_buffer_out === '0) && (b0.o_loading_busy === 1'b0) &&
                   (b0.o_load_done === 1'b0) && (b0.o_load_aborted === 1'b0) &&
                   (b0.o_start_error === 1'b0);
        rst_seen = 1;
      end else if (rst_seen) begin
        rst = 1'b0;
      end
    end
    b0.i_abort = 1'b0;
    b0.i_load_image_start = 1'b0;
    rst = 1'b0;
  endtask

  task automatic drive_load1(input int idx, input bit ord, output int done_cyc,
      output int ena_cnt, output int addr_bad);
    done_cyc = -1; ena_cnt = 0; addr_bad = 0;
    b1.i_load_image_start = 1'b1;
    b1.i_image_index      = 2'(idx);
    b1.i_pixel_order      = ord;
    @(negedge clk);
    b1.i_load_image_start = 1'b0;
    b1.i_pixel_order      = ~ord;
    for (int c = 0; c < 40; c++) begin
      if (c > 0) @(negedge clk);
      if (b1.o_bram_ena) begin
        ena_cnt++;
        if (b1.o_bram_addr !== AW1'(idx*WPI1 + c)) addr_bad++;
      end
      if (b1.o_load_done) begin
        done_cyc = c;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_chk++; if (b0.o_image_buffer_out !== '0) $display("FAIL rst_image: got nonzero, want 0"); else n_pass++;
    n_chk++; if ({b0.o_bram_ena, b0.o_loading_busy, b0.o_load_done, b0.o_load_aborted, b0.o_start_error} !== 5'b0)
      $display("FAIL rst_ctrl: got %b want 00000", {b0.o_bram_ena, b0.o_loading_busy, b0.o_load_done, b0.o_load_aborted, b0.o_start_error}); else n_pass++;
    n_chk++; if (b0.o_bram_addr !== '0) $display("FAIL rst_addr: got %0d want 0", b0.o_bram_addr); else n_pass++;
    n_chk++; if ({b1.o_bram_ena, b1.o_loading_busy, b1.o_bram_addr} !== '0) $display("FAIL rst_small: got nonzero want 0"); else n_pass++;
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic();
    int dc, ec, ab, ac, eaa, bb; bit rz;
    for (int k = 0; k < WPI0; k++) mem0[k] = {8{8'(k)}};
    drive_load0(0, 1'b0, -1, -1, -1, dc, ec, ab, ac, eaa, bb, rz);
    n_chk++; if (dc !== 101) $display("FAIL basic_done_cycle: got %0d want 101", dc); else n_pass++;
    n_chk++; if (ec !== WPI0) $display("FAIL basic_ena_count: got %0d want %0d", ec, WPI0); else n_pass++;
    n_chk++; if (ab !== 0) $display("FAIL basic_addr_seq: got %0d bad want 0", ab); else n_pass++;
    n_chk++; if (bb !== 0) $display("FAIL basic_busy: got %0d low cycles want 0", bb); else n_pass++;
    n_chk++; if (b0.o_image_buffer_out[6271:6264] !== 8'h00) $display("FAIL basic_px0: got %h want 00", b0.o_image_buffer_out[6271:6264]); else n_pass++;
    n_chk++; if (b0.o_image_buffer_out[7:0] !== 8'h61) $display("FAIL basic_px783: got %h want 61", b0.o_image_buffer_out[7:0]); else n_pass++;
    n_chk++; if (img_bad0(0, 1'b0) !== 0) $display("FAIL basic_image: got %0d bad pixels want 0", img_bad0(0, 1'b0)); else n_pass++;
  endtask

  task automatic test_index_random();
    int dc, ec, ab, ac, eaa, bb; bit rz; bit ord;
    ord = 1'($urandom);
    @(negedge clk);
    drive_load0(3, ord, -1, -1, -1, dc, ec, ab, ac, eaa, bb, rz);
    n_chk++; if (dc !== 101) $display("FAIL idx3_done_cycle: got %0d want 101", dc); else n_pass++;
    n_chk++; if (ab !== 0 || ec !== WPI0) $display("FAIL idx3_addr_294: got %0d bad / %0d issued want 0 / 98", ab, ec); else n_pass++;
    n_chk++; if (img_bad0(3, ord) !== 0) $display("FAIL idx3_image: got %0d bad pixels want 0", img_bad0(3, ord)); else n_pass++;
  endtask

  task automatic test_order_back_to_back();
    int dc, ec, ab, ac, eaa, bb, bad; bit rz;
    mem0[0] = 64'h0706050403020100;
    @(negedge clk);
    drive_load0(0, 1'b1, -1, -1, -1, dc, ec, ab, ac, eaa, bb, rz);
    bad = 0;
    for (int r = 0; r < 8; r++) if (out0(r) !== 8'(r)) bad++;
    n_chk++; if (bad !== 0) $display("FAIL order1_px0_7: got %0d wrong want 0", bad); else n_pass++;
    // Next start lands in the DONE cycle itself.
    drive_load0(0, 1'b0, -1, -1, -1, dc, ec, ab, ac, eaa, bb, rz);
    n_chk++; if (dc !== 101) $display("FAIL b2b_done_cycle: got %0d want 101", dc); else n_pass++;
    n_chk++; if (out0(0) !== 8'h07) $display("FAIL order0_px0: got %h want 07", out0(0)); else n_pass++;
    n_chk++; if (out0(7) !== 8'h00) $display("FAIL order0_px7: got %h want 00", out0(7)); else n_pass++;
  endtask

  task automatic test_abort();
    int dc, ec, ab, ac, eaa, bb; bit rz; bit orda, ordb;
    orda = 1'($urandom); ordb = 1'($urandom);
    @(negedge clk);
    drive_load0(5, orda, -1, -1, -1, dc, ec, ab, ac, eaa, bb, rz);
    n_chk++; if (dc !== 101) $display("FAIL abortA_done: got %0d want 101", dc); else n_pass++;
    @(negedge clk);
    drive_load0(9, ordb, 39, -1, -1, dc, ec, ab, ac, eaa, bb, rz);
    n_chk++; if (ec !== 40) $display("FAIL abort_issues: got %0d want 40", ec); else n_pass++;
    n_chk++; if (ac !== 40) $display("FAIL abort_pulse_cycle: got %0d want 40", ac); else n_pass++;
    n_chk++; if (dc !== -1 || eaa !== 0) $display("FAIL abort_quiet: got done %0d / ena %0d want -1 / 0", dc, eaa); else n_pass++;
    n_chk++; if (b0.o_loading_busy !== 1'b0) $display("FAIL abort_busy: got %b want 0", b0.o_loading_busy); else n_pass++;
    n_chk++; if (img_bad0(5, orda) !== 0) $display("FAIL abort_keeps_A: got %0d bad pixels want 0", img_bad0(5, orda)); else n_pass++;
    // Abort on the same edge as the final capture.
    @(negedge clk);
    drive_load0(9, ordb, 99, -1, -1, dc, ec, ab, ac, eaa, bb, rz);
    n_chk++; if (dc !== -1 || ac !== 100) $display("FAIL abort_final: got done %0d / abort %0d want -1 / 100", dc, ac); else n_pass++;
    n_chk++; if (img_bad0(5, orda) !== 0) $display("FAIL abort_final_keeps_A: got %0d bad want 0", img_bad0(5, orda)); else n_pass++;
    @(negedge clk);
    drive_load0(9, ordb, -1, -1, -1, dc, ec, ab, ac, eaa, bb, rz);
    n_chk++; if (dc !== 101 || img_bad0(9, ordb) !== 0) $display("FAIL abort_then_B: got done %0d bad %0d want 101 / 0", dc, img_bad0(9, ordb)); else n_pass++;
  endtask

  task automatic test_midstart_reset();
    int dc, ec, ab, ac, eaa, bb; bit rz;
    @(negedge clk);
    drive_load0(7, 1'b0, -1, -1, 30, dc, ec, ab, ac, eaa, bb, rz);
    n_chk++; if (dc !== 101 || ab !== 0 || ec !== WPI0) $display("FAIL midstart_seq: got done %0d bad %0d ena %0d want 101 0 98", dc, ab, ec); else n_pass++;
    n_chk++; if (img_bad0(7, 1'b0) !== 0) $display("FAIL midstart_image: got %0d bad want 0", img_bad0(7, 1'b0)); else n_pass++;
    @(negedge clk);
    drive_load0(2, 1'b1, -1, 50, -1, dc, ec, ab, ac, eaa, bb, rz);
    n_chk++; if (rz !== 1'b1) $display("FAIL reset_outputs_zero: got %b want 1", rz); else n_pass++;
    n_chk++; if (dc !== -1) $display("FAIL reset_no_done: got %0d want -1", dc); else n_pass++;
    @(negedge clk);
    drive_load0(11, 1'b0, -1, -1, -1, dc, ec, ab, ac, eaa, bb, rz);
    n_chk++; if (dc !== 101 || img_bad0(11, 1'b0) !== 0) $display("FAIL reset_then_load: got done %0d bad %0d want 101 / 0", dc, img_bad0(11, 1'b0)); else n_pass++;
  endtask

  task automatic test_start_rules();
    int ena_seen;
    @(negedge clk);
    b0.i_load_image_start = 1'b1; b0.i_abort = 1'b1; b0.i_image_index = 4'd4;
    @(negedge clk);
    b0.i_load_image_start = 1'b0; b0.i_abort = 1'b0;
    n_chk++; if ({b0.o_bram_ena, b0.o_loading_busy, b0.o_load_aborted, b0.o_start_error} !== 4'b0)
      $display("FAIL start_with_abort: got %b want 0000", {b0.o_bram_ena, b0.o_loading_busy, b0.o_load_aborted, b0.o_start_error}); else n_pass++;
    b0.i_abort = 1'b1;
    @(negedge clk);
    b0.i_abort = 1'b0;
    n_chk++; if ({b0.o_load_aborted, b0.o_loading_busy} !== 2'b0) $display("FAIL idle_abort: got %b want 00", {b0.o_load_aborted, b0.o_loading_busy}); else n_pass++;
    b1.i_load_image_start = 1'b1; b1.i_image_index = 2'd3; b1.i_abort = 1'b0;
    @(negedge clk);
    b1.i_load_image_start = 1'b0;
    n_chk++; if ({b1.o_start_error, b1.o_loading_busy} !== 2'b10) $display("FAIL bad_index_pulse: got %b want 10", {b1.o_start_error, b1.o_loading_busy}); else n_pass++;
    ena_seen = 0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (b1.o_bram_ena || b1.o_start_error || b1.o_loading_busy) ena_seen++;
    end
    n_chk++; if (ena_seen !== 0) $display("FAIL bad_index_quiet: got %0d active cycles want 0", ena_seen); else n_pass++;
  endtask

  task automatic test_small();
    int dc, ec, ab, idx; bit ord;
    for (int t = 0; t < 4; t++) begin
      idx = int'($urandom_range(0, NI1-1));
      ord = 1'($urandom);
      @(negedge clk);
      drive_load1(idx, ord, dc, ec, ab);
      n_chk++; if (dc !== 6 || ec !== 2 || ab !== 0) $display("FAIL small_timing: got done %0d ena %0d bad %0d want 6 2 0", dc, ec, ab); else n_pass++;
      n_chk++; if (img_bad1(idx, ord) !== 0) $display("FAIL small_image: got %0d bad pixels want 0", img_bad1(idx, ord)); else n_pass++;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    b0.i_load_image_start = 1'b0; b0.i_image_index = '0; b0.i_pixel_order = 1'b0; b0.i_abort = 1'b0;
    b1.i_load_image_start = 1'b0; b1.i_image_index = '0; b1.i_pixel_order = 1'b0; b1.i_abort = 1'b0;
    for (int i = 0; i < NI0*WPI0; i++) mem0[i] = {$urandom, $urandom};
    for (int i = 0; i < NI1*WPI1; i++) mem1[i] = {$urandom, $urandom};
    test_reset();
    test_basic();
    test_index_random();
    test_order_back_to_back();
    test_abort();
    test_midstart_reset();
    test_start_rules();
    test_small();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
